// File: rtl/hls_run_sequencer.sv
// Start/done run controller for NUM_CH lockstep HLS kernels with per-run latency and timeout.
// Optional min/max latency statistics are built when HLS_RUN_STATS_EN is defined.
module hls_run_sequencer #(
    parameter int          NUM_CH  = 2,
    parameter int          CNT_W   = 32,
    parameter int          RUNS_W  = 8,
    parameter longint      TIMEOUT = 200000000,
    parameter int          SETTLE  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [RUNS_W-1:0] num_runs,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] start_port,
    input  logic [NUM_CH-1:0] done_port,
    output logic              busy,
    output logic              run_valid,
    output logic [CNT_W-1:0]  last_cycles,
    output logic [RUNS_W-1:0] run_idx,
    output logic              all_done,
    output logic              timeout_flag,
    output logic [CNT_W-1:0]  min_cycles,
    output logic [CNT_W-1:0]  max_cycles
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_REPORT,
        S_FINISH,
        S_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [RUNS_W-1:0]  runs_q, runs_d;
    logic [RUNS_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic               all_done_q, all_done_d;
    logic               to_q, to_d;

    logic               accept;
    logic [NUM_CH-1:0]  pend_now;
    logic [CNT_W-1:0]   cnt_inc;
    logic [RUNS_W:0]    idx_next;

    assign accept   = (state_q == S_IDLE) && go && (|ch_en);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign idx_next = {1'b0, idx_q} + 1'b1;
    // In START the pending set is the full latched mask; done pulses on disabled channels fall out here.
    assign pend_now = ((state_q == S_START) ? mask_q : pend_q) & ~done_port;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        set_d      = set_q;
        runs_d     = runs_q;
        idx_d      = idx_q;
        last_d     = last_q;
        all_done_d = all_done_q;
        to_d       = to_q;
        start_port = '0;
        busy       = 1'b0;
        run_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mask_d     = ch_en;
                    runs_d     = (num_runs == '0) ? RUNS_W'(1) : num_runs;
                    idx_d      = '0;
                    all_done_d = 1'b0;
                    to_d       = 1'b0;
                    set_d      = '0;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (set_q == SET_LAST) begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_START;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            S_START, S_WAIT: begin
                busy   = 1'b1;
                pend_d = pend_now;
                cnt_d  = cnt_inc;
                if (state_q == S_START) start_port = mask_q;
                // Completion wins over timeout when both land in the same cycle.
                if (pend_now == '0) begin
                    last_d  = cnt_q;
                    state_d = S_REPORT;
                end else if (cnt_q > TO_LIM) begin
                    to_d    = 1'b1;
                    state_d = S_TIMEOUT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_REPORT: begin
                busy      = 1'b1;
                run_valid = 1'b1;
                if (idx_next < {1'b0, runs_q}) begin
                    idx_d   = idx_next[RUNS_W-1:0];
                    set_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    all_done_d = 1'b1;
                    state_d    = S_FINISH;
                end
            end
            S_FINISH:  state_d = S_IDLE;
            S_TIMEOUT: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
            set_q      <= '0;
            runs_q     <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            all_done_q <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            set_q      <= set_d;
            runs_q     <= runs_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            all_done_q <= all_done_d;
            to_q       <= to_d;
        end
    end

    assign last_cycles  = last_q;
    assign run_idx      = idx_q;
    assign all_done     = all_done_q;
    assign timeout_flag = to_q;

`ifdef HLS_RUN_STATS_EN
    logic [CNT_W-1:0] min_q, max_q;

    // last_q is already valid during REPORT, so stats settle one cycle after run_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else if (accept) begin
            min_q <= '0;
            max_q <= '0;
        end else if (state_q == S_REPORT) begin
            if (idx_q == '0) begin
                min_q <= last_q;
                max_q <= last_q;
            end else begin
                if (last_q < min_q) min_q <= last_q;
                if (last_q > max_q) max_q <= last_q;
            end
        end
    end

    assign min_cycles = min_q;
    assign max_cycles = max_q;
`else
    assign min_cycles = '0;
    assign max_cycles = '0;
`endif

endmodule
